// File: rtl/spi_master_pkg.sv
// Shared types for the transmit-only SPI master.
package spi_master_pkg;

  // Frame sequencer states: idle, pre-clock setup, clocked shifting, post-clock hold.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake, configuration, write port and SPI pins of spi_master.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  sclk;
  logic                  mosi;
  logic                  cs_n;
  logic                  cpol;
  logic                  cpha;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_empty;
  logic                  fifo_full;

  // The SPI master itself.
  modport master (
    input  start, cpol, cpha, fifo_wr_en, fifo_wr_data,
    output busy, sclk, mosi, cs_n, fifo_empty, fifo_full
  );

  // The host / environment driving the master.
  modport slave (
    output start, cpol, cpha, fifo_wr_en, fifo_wr_data,
    input  busy, sclk, mosi, cs_n, fifo_empty, fifo_full
  );
endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous write FIFO with first-word-fall-through read data and
// registered empty/full flags.
module spi_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Pushes into a full FIFO and pops from an empty one are ignored.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; pointers and count define validity.
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered flags; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_COUNT);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Transmit-only SPI master: queues words in a FIFO and sends all of them
// MSB-first inside one chip-select frame, in any of the four CPOL/CPHA modes.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  // The FIFO is sized purely by its pointer width, so the two must agree.
  if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("spi_master: FIFO_DEPTH must equal 2**ADDR_WIDTH");
  end

  localparam int                DIV_W     = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int                EDGE_W    = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  spi_state_e            state;
  logic [DIV_W-1:0]      div_cnt;    // clk cycles within the current SCLK half-period
  logic [EDGE_W-1:0]     edge_cnt;   // SCLK edge index within the current word
  logic [DATA_WIDTH-1:0] shift_reg;  // bits still to be presented, MSB first
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  busy_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  sclk_q;

  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic                  half_done;
  logic                  start_ok;
  logic                  word_done;

  spi_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.fifo_wr_en),
    .wr_data (bus.fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // A pop happens when a frame starts and when a word ends with more queued.
  assign half_done  = (div_cnt == DIV_LAST);
  assign start_ok   = (state == ST_IDLE) && bus.start && !fifo_empty;
  assign word_done  = (state == ST_SHIFT) && half_done && (edge_cnt == EDGE_LAST);
  assign fifo_rd_en = start_ok || (word_done && !fifo_empty);

  assign bus.busy       = busy_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.mosi       = mosi_q;
  assign bus.sclk       = sclk_q;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_full  = fifo_full;

  // Frame sequencer with SCLK divider, edge counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      shift_reg <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          sclk_q   <= bus.cpol;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start_ok) begin
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
            busy_q <= 1'b1;
            cs_n_q <= 1'b0;
            // With cpha=0 the MSB must be valid before the first leading edge.
            if (!bus.cpha) begin
              mosi_q    <= fifo_rd_data[DATA_WIDTH-1];
              shift_reg <= fifo_rd_data << 1;
            end else begin
              mosi_q    <= 1'b0;
              shift_reg <= fifo_rd_data;
            end
            state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (half_done) begin
            div_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (!half_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (edge_cnt == EDGE_LAST) begin
              // Final trailing edge: chain the next word or wind the frame down.
              edge_cnt <= '0;
              if (!fifo_empty) begin
                if (!cpha_q) begin
                  mosi_q    <= fifo_rd_data[DATA_WIDTH-1];
                  shift_reg <= fifo_rd_data << 1;
                end else begin
                  shift_reg <= fifo_rd_data;
                end
              end else begin
                state <= ST_HOLD;
              end
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
              // Even edge index = leading edge. cpha=1 drives on leading,
              // cpha=0 drives on trailing edges.
              if (edge_cnt[0] != cpha_q) begin
                mosi_q    <= shift_reg[DATA_WIDTH-1];
                shift_reg <= shift_reg << 1;
              end
            end
          end
        end

        ST_HOLD: begin
          if (half_done) begin
            div_cnt <= '0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // cpol_q is captured for the whole frame; SCLK itself carries the idle level.
  logic unused_cpol;
  assign unused_cpol = cpol_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed mode/burst/bounds/reset cases
// plus randomized frames, checked against a word-queue reference model.
module tb_spi_master;

  localparam int DW = 8;
  localparam int H  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_master_if #(.DATA_WIDTH(DW)) bus ();

  spi_master #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (4),
    .CLK_DIV    (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words the FIFO should hold, in order, capacity DEPTH.
  logic [DW-1:0] model_q[$];

  // Mode the monitor decodes with; written by stimulus only.
  bit exp_cpol = 1'b0;
  bit exp_cpha = 1'b0;

  // Monitor totals (written only by the monitor).
  bit cap_bits[$];
  int busy_total = 0;
  int cs_falls   = 0;
  int edge_total = 0;
  logic prev_sclk = 1'b0;
  logic prev_cs   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave-side view of the wire: samples mosi on the mode's sampling edge.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_total++;
    if (prev_cs === 1'b1 && bus.cs_n === 1'b0) cs_falls++;
    if (bus.cs_n === 1'b0 && bus.sclk !== prev_sclk) begin
      edge_total++;
      if (bus.sclk === (exp_cpol ~^ exp_cpha)) cap_bits.push_back(bus.mosi);
    end
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs_n;
  end

  task automatic push(input logic [DW-1:0] w);
    @(negedge clk);
    bus.fifo_wr_en   = 1'b1;
    bus.fifo_wr_data = w;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    @(negedge clk);
    bus.fifo_wr_en = 1'b0;
  endtask

  // Sends whatever the model holds and checks the frame on the wire.
  task automatic run_frame(input bit pol, input bit pha, input bit extend, input bit flip);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    logic [DW-1:0] extra;
    int bits0, busy0, cs0, edge0, n;
    bit done;
    exp_cpol = pol;
    exp_cpha = pha;
    bus.cpol = pol;
    bus.cpha = pha;
    repeat (2) @(negedge clk);
    check("sclk_idle", bus.sclk, pol);
    check("empty_before", bus.fifo_empty, model_q.size() == 0);
    bits0 = cap_bits.size();
    busy0 = busy_total;
    cs0   = cs_falls;
    edge0 = edge_total;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    check("cs_low", bus.cs_n, 0);
    exp_q = model_q;
    model_q.delete();
    extra = DW'($urandom);
    done = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (extend && cyc == 4) begin
        bus.fifo_wr_en   = 1'b1;
        bus.fifo_wr_data = extra;
        exp_q.push_back(extra);
      end
      if (extend && cyc == 5) bus.fifo_wr_en = 1'b0;
      if (flip && cyc == 10) bus.cpol = ~pol;
      if (bus.busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check("frame_done", done, 1);
    n = exp_q.size();
    check("busy_cycles", busy_total - busy0, (2 * DW * n + 2) * H);
    check("cs_frames", cs_falls - cs0, 1);
    check("sclk_edges", edge_total - edge0, 2 * DW * n);
    check("bit_count", cap_bits.size() - bits0, DW * n);
    if (cap_bits.size() - bits0 == DW * n) begin
      for (int i = 0; i < n; i++) begin
        w = '0;
        for (int b = 0; b < DW; b++) w = {w[DW-2:0], cap_bits[bits0 + DW * i + b]};
        check($sformatf("word%0d", i), w, exp_q[i]);
      end
    end
    check("cs_end", bus.cs_n, 1);
    check("mosi_end", bus.mosi, 0);
    check("empty_end", bus.fifo_empty, 1);
    bus.cpol = pol;
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.cpol         = 1'b0;
    bus.cpha         = 1'b0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_cs_n", bus.cs_n, 1);
    check("rst_mosi", bus.mosi, 0);
    check("rst_sclk", bus.sclk, 0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_full", bus.fifo_full, 0);
    rst = 1'b0;

    // All four modes with A5.
    for (int m = 0; m < 4; m++) begin
      push(8'hA5);
      run_frame(m[1], m[0], 1'b0, 1'b0);
    end

    // Burst of two words in one frame.
    push(8'h3C);
    push(8'hC3);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // FIFO bounds: 16 fill it, 17th dropped.
    for (int i = 0; i < DEPTH; i++) begin
      push(DW'(8'h10 + i));
      if (i == DEPTH - 2) check("not_full_15", bus.fifo_full, 0);
    end
    check("full_16", bus.fifo_full, 1);
    push(8'hEE);
    check("full_17", bus.fifo_full, 1);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    // Start on an empty FIFO is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("empty_start_busy", bus.busy, 0);
    check("empty_start_cs", bus.cs_n, 1);

    // cpol toggled mid-frame must not disturb the frame.
    push(8'h96);
    run_frame(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a word.
    exp_cpol = 1'b0;
    exp_cpha = 1'b0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    push(8'hA5);
    push(8'h0F);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", bus.cs_n, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_sclk", bus.sclk, 0);
    check("abort_empty", bus.fifo_empty, 1);
    check("abort_mosi", bus.mosi, 0);
    rst = 1'b0;
    model_q.delete();
    push(8'h5A);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames; one extended by a push during the frame.
    for (int t = 0; t < 8; t++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) push(DW'($urandom));
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t == 2 || t == 5, t == 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Transmit-only SPI master with an integrated write FIFO and run-time selectable CPOL/CPHA (modes 0–3). Host logic queues words through a simple write port, then pulses `start`. The block asserts `cs_n` and shifts every queued word out MSB-first on `mosi` in one chip-select frame. It sits between an on-chip controller and an external SPI slave. There is no MISO path.

## Interface
- `DATA_WIDTH`, 8, bits per SPI word.
- `FIFO_DEPTH`, 16, FIFO entries; must equal 2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, 4, FIFO pointer width.
- `CLK_DIV`, 2, SCLK half-period in `clk` cycles (H); must be ≥1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a frame.
- `busy`  out  1  high while a frame is in progress.
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  serial data, MSB first.
- `cs_n`  out  1  chip select, active-low.
- `cpol`  in  1  idle level of `sclk`.
- `cpha`  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- `fifo_wr_en`  in  1  push `fifo_wr_data`.
- `fifo_wr_data`  in  DATA_WIDTH  word to queue.
- `fifo_empty`  out  1  FIFO holds 0 words.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH words.

## Operation
- Reset values: `busy`=0, `cs_n`=1, `mosi`=0, `sclk`=0, `fifo_empty`=1, `fifo_full`=0. Reset also clears the FIFO and the FSM.
- FIFO behaviour:
  - A push is accepted when `fifo_wr_en` && !`fifo_full`. A push while full is dropped silently.
  - A simultaneous push and pop leaves the count unchanged.
  - The count is ADDR_WIDTH+1 bits wide and the pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - `sclk` is registered from `cpol` every cycle.
  - `start` with `fifo_empty`=0 latches `cpol` and `cpha`, pops one word into the shift register, and moves to SETUP.
  - `start` with an empty FIFO is ignored.
- SETUP:
  - `cs_n`=0, `busy`=1, `sclk` = latched cpol.
  - If cpha=0, `mosi` shows the MSB immediately.
  - Lasts H cycles, then moves to SHIFT.
- SHIFT:
  - `sclk` toggles every H cycles, giving 2*DATA_WIDTH edges per word.
  - cpha=0: `mosi` updates on each trailing edge (except after the final bit).
  - cpha=1: `mosi` updates on each leading edge, starting with the MSB on the first leading edge.
  - After the last trailing edge, `sclk` is back at the idle level. Then:
    - If the FIFO is non-empty, pop the next word and continue without a gap. With cpha=0, the new MSB appears at that same edge.
    - If the FIFO is empty, go to HOLD.
- HOLD: H cycles with `cs_n`=0, then `cs_n`=1, `busy`=0, `mosi`=0, and return to IDLE.
- Changes to `cpol`/`cpha` while `busy` have no effect until the next IDLE.
- `start` while `busy` is ignored.
- Pushes during a frame are allowed and extend the frame if they land before the current word's final edge.

## Timing
- `busy`/`cs_n` change on the clock edge after `start` is sampled.
- A single word holds `busy` high for (2*DATA_WIDTH+2)*H cycles; with the defaults that is 36 cycles.
- Each additional back-to-back word adds 2*DATA_WIDTH*H cycles.
- `fifo_empty`/`fifo_full` are registered and reflect a push or pop one cycle later.
- Reset asserted mid-frame aborts immediately. The cycle after reset, all outputs hold their reset values.

## Structure
- Package `spi_master_pkg`: FSM state enum.
- Sub-module `spi_tx_fifo`: synchronous FIFO, parameterised by DATA_WIDTH/ADDR_WIDTH, with wr_en/wr_data/rd_en/rd_data/empty/full ports.
- Top level: FSM, SCLK half-period counter, bit counter, shift register.

## Test plan
- Mode 0 (cpol=0, cpha=0): push 8'hA5, pulse `start`.
  - `sclk` idles low; 8 rising edges.
  - `mosi` sampled at rising edges = 1,0,1,0,0,1,0,1.
  - `busy` high for 36 cycles, then `cs_n`=1.
- Modes 1, 2, 3, each with 8'hA5:
  - Mode 1: `mosi` sampled on falling edges gives A5.
  - Mode 2: idle `sclk`=1; sampled on falling edges gives A5.
  - Mode 3: idle `sclk`=1; sampled on rising edges gives A5.
- Burst: push 8'h3C and 8'hC3, one `start`.
  - Single `cs_n` low period, 16 sampled bits = 3C then C3.
  - `busy` = 68 cycles; `fifo_empty`=1 afterwards.
- FIFO bounds:
  - 16 pushes set `fifo_full`=1; a 17th push is dropped.
  - The frame sends exactly 16 words, in order.
- `start` with an empty FIFO: `busy` and `cs_n` unchanged. Toggling `cpol` mid-frame does not alter that frame.
- `rst`=1 mid-word:
  - Next cycle `cs_n`=1, `busy`=0, `sclk`=0, `fifo_empty`=1.
  - A subsequent push of 8'h5A plus `start` transmits cleanly.
